// File: rtl/fmc_chk_pkg.sv
// Shared definitions for the FMC PRBS checker and the matching transmitter.
//   - chk_state_t : checker state encoding
//   - LFSR_TAPS   : tap mask for x^32 + x^22 + x^2 + x + 1
//   - lfsr_next() : one LFSR step, shift left with feedback into bit 0
//   - sat_inc()   : saturating increment for the status counters
package fmc_chk_pkg;

    localparam int CNT_W = 16;

    // Bits 31, 21, 1, 0 of the current word feed the new LSB.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        CHECK = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } chk_state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] w);
        return {w[30:0], ^(w & LFSR_TAPS)};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/prbs32_step.sv
// Combinational 32-bit LFSR next-word function, shared with the FMC transmitter.
//   word      : current LFSR word
//   next_word : word one LFSR step later
module prbs32_step
    import fmc_chk_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] next_word
);

    assign next_word = lfsr_next(word);

endmodule

// File: rtl/fmc_prbs_checker.sv
// Receive-side checker for the FMC PRBS test stream. Seeds itself from the
// first non-zero valid word, then predicts and compares every following word.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   data_in, data_valid: received word and its qualifier
//   gpio_out_pass/fail : sticky pass / fail indications
//   led                : heartbeat while checking, 1 on pass, 0 on fail
//   err_cnt, word_cnt  : saturating mismatch / checked-word counts
//   locked             : high from seed capture until fail or reset
//
// state | meaning
// ------+--------------------------------------------------------------
// SEED  | waiting for a non-zero valid word to seed the predictor
// CHECK | comparing each valid word; counting the error-free run
// PASS  | PASS_WORDS clean words seen; still counts errors, never leaves
// FAIL  | mismatch or watchdog expiry; everything frozen until reset
module fmc_prbs_checker
    import fmc_chk_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PASS_WORDS = 1024,
    parameter int TIMEOUT    = 65535,
    parameter int LED_DIV    = 24
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              gpio_out_pass,
    output logic              gpio_out_fail,
    output logic              led,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              locked
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int GR_W = $clog2(PASS_WORDS + 1);

    chk_state_t          state, state_nxt;
    logic [31:0]         expected, expected_nxt;
    logic [WD_W-1:0]     wd, wd_nxt, wd_inc;
    logic [GR_W-1:0]     good, good_nxt, good_inc;
    logic [LED_DIV-1:0]  div, div_nxt;
    logic [CNT_W-1:0]    err_nxt, word_nxt;
    logic                locked_nxt, led_nxt;
    logic [31:0]         seed_next, exp_step;

    prbs32_step u_seed_step (
        .word      (data_in),
        .next_word (seed_next)
    );

    prbs32_step u_exp_step (
        .word      (expected),
        .next_word (exp_step)
    );

    assign wd_inc   = wd + 1'b1;
    assign good_inc = good + 1'b1;

    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        wd_nxt       = wd;
        good_nxt     = good;
        div_nxt      = div;
        err_nxt      = err_cnt;
        word_nxt     = word_cnt;
        locked_nxt   = locked;

        case (state)
            SEED: begin
                div_nxt = div + 1'b1;
                if (data_valid) begin
                    wd_nxt = '0;
                    // All-zero is the LFSR lock-up word and cannot seed.
                    if (data_in != '0) begin
                        expected_nxt = seed_next;
                        locked_nxt   = 1'b1;
                        state_nxt    = CHECK;
                    end
                end else begin
                    wd_nxt = wd_inc;
                    if (wd_inc == WD_W'(TIMEOUT)) state_nxt = FAIL;
                end
            end

            CHECK: begin
                div_nxt = div + 1'b1;
                if (data_valid) begin
                    wd_nxt       = '0;
                    word_nxt     = sat_inc(word_cnt);
                    expected_nxt = exp_step;
                    // Mismatch wins over the run reaching PASS_WORDS.
                    if (data_in != expected) begin
                        err_nxt    = sat_inc(err_cnt);
                        good_nxt   = '0;
                        locked_nxt = 1'b0;
                        state_nxt  = FAIL;
                    end else begin
                        good_nxt = good_inc;
                        if (good_inc == GR_W'(PASS_WORDS)) state_nxt = PASS;
                    end
                end else begin
                    wd_nxt = wd_inc;
                    if (wd_inc == WD_W'(TIMEOUT)) begin
                        locked_nxt = 1'b0;
                        state_nxt  = FAIL;
                    end
                end
            end

            PASS: begin
                if (data_valid) begin
                    word_nxt     = sat_inc(word_cnt);
                    expected_nxt = exp_step;
                    if (data_in != expected) err_nxt = sat_inc(err_cnt);
                end
            end

            FAIL: begin
            end

            default: state_nxt = SEED;
        endcase

        case (state_nxt)
            PASS:    led_nxt = 1'b1;
            FAIL:    led_nxt = 1'b0;
            default: led_nxt = div_nxt[LED_DIV-1];
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state         <= SEED;
            expected      <= '0;
            wd            <= '0;
            good          <= '0;
            div           <= '0;
            err_cnt       <= '0;
            word_cnt      <= '0;
            locked        <= 1'b0;
            led           <= 1'b0;
            gpio_out_pass <= 1'b0;
            gpio_out_fail <= 1'b0;
        end else begin
            state         <= state_nxt;
            expected      <= expected_nxt;
            wd            <= wd_nxt;
            good          <= good_nxt;
            div           <= div_nxt;
            err_cnt       <= err_nxt;
            word_cnt      <= word_nxt;
            locked        <= locked_nxt;
            led           <= led_nxt;
            gpio_out_pass <= (state_nxt == PASS);
            gpio_out_fail <= (state_nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_fmc_prbs_checker.sv
module tb_fmc_prbs_checker;

    localparam int PASS_WORDS = 1024;
    localparam int TIMEOUT    = 100;
    localparam int LED_DIV    = 3;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [31:0] data_in;
    logic        data_valid;
    logic        gpio_out_pass;
    logic        gpio_out_fail;
    logic        led;
    logic [15:0] err_cnt;
    logic [15:0] word_cnt;
    logic        locked;

    int checks = 0;
    int errors = 0;

    fmc_prbs_checker #(
        .DATA_W     (32),
        .PASS_WORDS (PASS_WORDS),
        .TIMEOUT    (TIMEOUT),
        .LED_DIV    (LED_DIV)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .gpio_out_pass (gpio_out_pass),
        .gpio_out_fail (gpio_out_fail),
        .led           (led),
        .err_cnt       (err_cnt),
        .word_cnt      (word_cnt),
        .locked        (locked)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: mode 0 = seeding, 1 = checking, 2 = passed, 3 = failed.
    int          m_mode;
    logic [31:0] m_exp;
    int          m_err, m_words, m_good, m_idle, m_div;
    bit          m_locked;

    function automatic logic [31:0] ref_next(input logic [31:0] w);
        logic [31:0] fb;
        fb = ((w >> 31) ^ (w >> 21) ^ (w >> 1) ^ w) & 32'd1;
        return (w << 1) | fb;
    endfunction

    function automatic bit m_led();
        if (m_mode == 2) return 1'b1;
        if (m_mode == 3) return 1'b0;
        return bit'((m_div >> (LED_DIV - 1)) & 1);
    endfunction

    task automatic model_step(input logic rst_n, input logic v, input logic [31:0] d);
        if (!rst_n) begin
            m_mode = 0; m_exp = 0; m_err = 0; m_words = 0;
            m_good = 0; m_idle = 0; m_div = 0; m_locked = 0;
            return;
        end
        if (m_mode == 0 || m_mode == 1) begin
            m_div++;
            if (v) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_mode = 3;
                    m_locked = 0;
                    return;
                end
            end
        end
        if (!v) return;
        if (m_mode == 0) begin
            if (d != 0) begin
                m_exp = ref_next(d);
                m_locked = 1;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (m_words < 65535) m_words++;
            if (d != m_exp) begin
                if (m_err < 65535) m_err++;
                m_good = 0;
                m_mode = 3;
                m_locked = 0;
            end else begin
                m_good++;
                if (m_good == PASS_WORDS) m_mode = 2;
            end
            m_exp = ref_next(m_exp);
        end else if (m_mode == 2) begin
            if (m_words < 65535) m_words++;
            if (d != m_exp && m_err < 65535) m_err++;
            m_exp = ref_next(m_exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic v, input logic [31:0] d);
        sys_rst_n  = rst_n;
        data_valid = v;
        data_in    = d;
        @(posedge sys_clk);
        model_step(rst_n, v, d);
        #1;
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 6;
        if (gpio_out_pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %0b want 0", gpio_out_pass); end
        if (gpio_out_fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %0b want 0", gpio_out_fail); end
        if (led !== 1'b0)           begin errors++; $display("FAIL reset_led: got %0b want 0", led); end
        if (err_cnt !== 16'd0)      begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        if (word_cnt !== 16'd0)     begin errors++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
        if (locked !== 1'b0)        begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
    endtask

    task automatic test_lock_basic();
        apply_reset();
        drive(1'b1, 1'b1, 32'h1);
        checks += 2;
        if (locked !== 1'b1)    begin errors++; $display("FAIL lock_after_seed: got %0b want 1", locked); end
        if (word_cnt !== 16'd0) begin errors++; $display("FAIL lock_seed_not_counted: got %0d want 0", word_cnt); end
        drive(1'b1, 1'b1, 32'h3);
        drive(1'b1, 1'b1, 32'h6);
        drive(1'b1, 1'b1, 32'hD);
        checks += 5;
        if (word_cnt !== 16'd3)     begin errors++; $display("FAIL lock_word_cnt: got %0d want 3", word_cnt); end
        if (err_cnt !== 16'd0)      begin errors++; $display("FAIL lock_err_cnt: got %0d want 0", err_cnt); end
        if (locked !== 1'b1)        begin errors++; $display("FAIL lock_held: got %0b want 1", locked); end
        if (gpio_out_fail !== 1'b0) begin errors++; $display("FAIL lock_no_fail: got %0b want 0", gpio_out_fail); end
        if (led !== m_led())        begin errors++; $display("FAIL lock_heartbeat: got %0b want %0b", led, m_led()); end
    endtask

    task automatic test_pass();
        logic [31:0] w;
        apply_reset();
        drive(1'b1, 1'b1, 32'hDEADBEEF);
        w = ref_next(32'hDEADBEEF);
        for (int i = 1; i <= PASS_WORDS; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) drive(1'b1, 1'b0, $urandom);
            if (i == PASS_WORDS) begin
                checks++;
                if (gpio_out_pass !== 1'b0) begin errors++; $display("FAIL pass_early: got %0b want 0", gpio_out_pass); end
            end
            drive(1'b1, 1'b1, w);
            w = ref_next(w);
        end
        checks += 5;
        if (gpio_out_pass !== 1'b1)  begin errors++; $display("FAIL pass_gpio: got %0b want 1", gpio_out_pass); end
        if (gpio_out_fail !== 1'b0)  begin errors++; $display("FAIL pass_no_fail: got %0b want 0", gpio_out_fail); end
        if (led !== 1'b1)            begin errors++; $display("FAIL pass_led: got %0b want 1", led); end
        if (word_cnt !== 16'd1024)   begin errors++; $display("FAIL pass_word_cnt: got %0d want 1024", word_cnt); end
        if (locked !== 1'b1)         begin errors++; $display("FAIL pass_locked: got %0b want 1", locked); end
        drive(1'b1, 1'b1, w ^ 32'h0000_0100);
        w = ref_next(w);
        drive(1'b1, 1'b1, w);
        checks += 3;
        if (err_cnt !== 16'd1)      begin errors++; $display("FAIL pass_err_counted: got %0d want 1", err_cnt); end
        if (gpio_out_pass !== 1'b1) begin errors++; $display("FAIL pass_sticky: got %0b want 1", gpio_out_pass); end
        if (word_cnt !== 16'd1026)  begin errors++; $display("FAIL pass_word_cnt_cont: got %0d want 1026", word_cnt); end
    endtask

    task automatic test_mismatch();
        apply_reset();
        drive(1'b1, 1'b1, 32'h1);
        drive(1'b1, 1'b1, 32'h3);
        checks++;
        if (gpio_out_fail !== 1'b0) begin errors++; $display("FAIL mm_before: got %0b want 0", gpio_out_fail); end
        drive(1'b1, 1'b1, 32'h7);
        checks += 5;
        if (gpio_out_fail !== 1'b1) begin errors++; $display("FAIL mm_fail: got %0b want 1", gpio_out_fail); end
        if (gpio_out_pass !== 1'b0) begin errors++; $display("FAIL mm_pass: got %0b want 0", gpio_out_pass); end
        if (err_cnt !== 16'd1)      begin errors++; $display("FAIL mm_err_cnt: got %0d want 1", err_cnt); end
        if (locked !== 1'b0)        begin errors++; $display("FAIL mm_locked: got %0b want 0", locked); end
        if (led !== 1'b0)           begin errors++; $display("FAIL mm_led: got %0b want 0", led); end
        drive(1'b1, 1'b1, 32'hD);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, $urandom);
        checks += 3;
        if (err_cnt !== 16'd1)      begin errors++; $display("FAIL mm_err_frozen: got %0d want 1", err_cnt); end
        if (word_cnt !== 16'd2)     begin errors++; $display("FAIL mm_word_frozen: got %0d want 2", word_cnt); end
        if (gpio_out_fail !== 1'b1) begin errors++; $display("FAIL mm_sticky: got %0b want 1", gpio_out_fail); end
    endtask

    task automatic test_zero_seed();
        apply_reset();
        drive(1'b1, 1'b1, 32'h0);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL zero_no_lock: got %0b want 0", locked); end
        drive(1'b1, 1'b1, 32'h1);
        drive(1'b1, 1'b1, 32'h3);
        checks += 3;
        if (locked !== 1'b1)        begin errors++; $display("FAIL zero_then_lock: got %0b want 1", locked); end
        if (word_cnt !== 16'd1)     begin errors++; $display("FAIL zero_word_cnt: got %0d want 1", word_cnt); end
        if (err_cnt !== 16'd0)      begin errors++; $display("FAIL zero_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_timeout();
        apply_reset();
        drive(1'b1, 1'b1, 32'h1);
        for (int i = 0; i < TIMEOUT - 1; i++) drive(1'b1, 1'b0, 32'h0);
        checks++;
        if (gpio_out_fail !== 1'b0) begin errors++; $display("FAIL to_early: got %0b want 0", gpio_out_fail); end
        drive(1'b1, 1'b0, 32'h0);
        checks += 3;
        if (gpio_out_fail !== 1'b1) begin errors++; $display("FAIL to_fail: got %0b want 1", gpio_out_fail); end
        if (err_cnt !== 16'd0)      begin errors++; $display("FAIL to_err_cnt: got %0d want 0", err_cnt); end
        if (locked !== 1'b0)        begin errors++; $display("FAIL to_locked: got %0b want 0", locked); end

        apply_reset();
        drive(1'b1, 1'b1, 32'h1);
        for (int i = 0; i < TIMEOUT - 1; i++) drive(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h3);
        checks += 3;
        if (gpio_out_fail !== 1'b0) begin errors++; $display("FAIL to_rescued: got %0b want 0", gpio_out_fail); end
        if (word_cnt !== 16'd1)     begin errors++; $display("FAIL to_rescued_word: got %0d want 1", word_cnt); end
        if (locked !== 1'b1)        begin errors++; $display("FAIL to_rescued_lock: got %0b want 1", locked); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w, s;
        apply_reset();
        s = $urandom | 32'h1;
        drive(1'b1, 1'b1, s);
        w = ref_next(s);
        for (int i = 0; i < 500; i++) begin
            drive(1'b1, 1'b1, w);
            w = ref_next(w);
        end
        checks++;
        if (word_cnt !== 16'd500) begin errors++; $display("FAIL rm_before: got %0d want 500", word_cnt); end
        drive(1'b0, 1'b1, w);
        checks += 4;
        if (locked !== 1'b0)    begin errors++; $display("FAIL rm_locked: got %0b want 0", locked); end
        if (word_cnt !== 16'd0) begin errors++; $display("FAIL rm_word_cnt: got %0d want 0", word_cnt); end
        if (led !== 1'b0)       begin errors++; $display("FAIL rm_led: got %0b want 0", led); end
        if ({gpio_out_pass, gpio_out_fail} !== 2'b00) begin errors++; $display("FAIL rm_gpio: got %b want 00", {gpio_out_pass, gpio_out_fail}); end
        s = 32'h1234_5678;
        drive(1'b1, 1'b1, s);
        drive(1'b1, 1'b1, ref_next(s));
        checks += 2;
        if (locked !== 1'b1)    begin errors++; $display("FAIL rm_relock: got %0b want 1", locked); end
        if (word_cnt !== 16'd1) begin errors++; $display("FAIL rm_relock_word: got %0d want 1", word_cnt); end
    endtask

    task automatic test_random();
        int burst;
        logic v;
        logic [31:0] d;
        apply_reset();
        burst = 0;
        for (int it = 0; it < 5000; it++) begin
            int r;
            r = $urandom_range(0, 999);
            if (burst > 0) begin
                burst--;
                drive(1'b1, 1'b0, $urandom);
            end else if (r < 3) begin
                burst = $urandom_range(TIMEOUT - 3, TIMEOUT + 3);
                drive(1'b1, 1'b0, $urandom);
            end else if (r < 5) begin
                drive(1'b0, 1'b0, 32'h0);
            end else begin
                v = ($urandom_range(0, 9) < 7);
                if (m_mode == 0)
                    d = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                else if (m_mode == 3)
                    d = $urandom;
                else if ($urandom_range(0, 1499) == 0)
                    d = m_exp ^ (32'h1 << $urandom_range(0, 31));
                else
                    d = m_exp;
                drive(1'b1, v, d);
            end
            checks++;
            if (gpio_out_pass !== (m_mode == 2) || gpio_out_fail !== (m_mode == 3) ||
                led !== m_led() || locked !== m_locked ||
                err_cnt !== 16'(m_err) || word_cnt !== 16'(m_words)) begin
                errors++;
                $display("FAIL random_cycle_%0d: got pass=%0b fail=%0b led=%0b locked=%0b err=%0d words=%0d want pass=%0b fail=%0b led=%0b locked=%0b err=%0d words=%0d",
                         it, gpio_out_pass, gpio_out_fail, led, locked, err_cnt, word_cnt,
                         (m_mode == 2), (m_mode == 3), m_led(), m_locked, m_err, m_words);
            end
        end
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        data_valid = 1'b0;
        data_in    = 32'h0;
        model_step(1'b0, 1'b0, 32'h0);
        test_reset();
        test_lock_basic();
        test_pass();
        test_mismatch();
        test_zero_seed();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
